// File: rtl/local_velocity_pkg.sv
// local_velocity_pkg: shared widths, FSM states and sign-magnitude helpers.
// Helpers work on 32-bit containers; callers pass the active word width n.
package local_velocity_pkg;
   localparam int N_DEF = 17;
   localparam int Q_DEF = 8;
   localparam logic [31:0] MAX_MAG = (32'd1 << (N_DEF - 1)) - 32'd1;
   typedef enum logic [2:0] {IDLE, CAPTURE, SUM, MUL_VX, MUL_VY, MUL_WZ, DONE} state_t;
   function automatic logic [31:0] mag_mask(input int n);
      return (32'd1 << (n - 1)) - 32'd1;
   endfunction
   function automatic logic signed [31:0] sm_to_tc(input logic [31:0] sm, input int n);
      logic signed [31:0] m;
      m = $signed(sm & mag_mask(n));
      return (((sm >> (n - 1)) & 32'd1) != 32'd0) ? -m : m;
   endfunction
   // Returns {magnitude, sat}; the sign is simply the input's sign bit.
   function automatic logic [32:0] tc_to_sm_sat(input logic signed [31:0] v, input int n);
      logic [31:0] a;
      a = v[31] ? -v : v;
      return (a > mag_mask(n)) ? {mag_mask(n), 1'b1} : {a, 1'b0};
   endfunction
   function automatic logic [31:0] sm_neg(input logic [31:0] sm, input int n);
      return ((sm & mag_mask(n)) == 32'd0) ? 32'd0 : sm ^ (32'd1 << (n - 1));
   endfunction
endpackage

// File: rtl/local_velocity_seq_mult.sv
// sm_serial_mult: magnitude-only LSB-first shift-add multiplier, one bit per enabled cycle,
// with Q truncation and clamp; done_o marks the cycle whose result is on mag_o/sat_o.
module sm_serial_mult
   import local_velocity_pkg::*;
#(
   parameter int N_WIDTH = N_DEF,
   parameter int Q_WIDTH = Q_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic [N_WIDTH-2:0] a_i,
   input  logic [N_WIDTH-2:0] b_i,
   output logic [N_WIDTH-2:0] mag_o,
   output logic               sat_o,
   output logic               done_o
);
   localparam int M = N_WIDTH - 1;
   localparam int CW = $clog2(M);
   localparam logic [2*M-1:0] MAX = {{M{1'b0}}, {M{1'b1}}};
   logic [2*M-1:0] acc_q, acc_d, prod;
   logic [CW-1:0] cnt_q, cnt_d;
   // Bit 0 restarts the accumulator, so channels chain without a load cycle.
   always_comb begin
      acc_d = ((cnt_q == '0) ? '0 : acc_q) + (b_i[cnt_q] ? ({{M{1'b0}}, a_i} << cnt_q) : '0);
      done_o = en_i && (cnt_q == CW'(M - 1));
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
      prod = acc_d >> Q_WIDTH;
      sat_o = prod > MAX;
      mag_o = sat_o ? MAX[M-1:0] : prod[M-1:0];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
endmodule

// File: rtl/local_velocity_seq.sv
// local_velocity_seq: mecanum forward kinematics with start/busy/done handshake, saturating
// sums and one serial multiplier shared across vx, vy and wz.
module local_velocity_seq
   import local_velocity_pkg::*;
#(
   parameter int                 N_WIDTH = N_DEF,
   parameter int                 Q_WIDTH = Q_DEF,
   parameter logic [N_WIDTH-1:0] K_LIN   = 'h00002,
   parameter logic [N_WIDTH-1:0] K_ANG   = 'h00005
) (
   input  logic               LOCAL_VELOCITY_SEQ_CLOCK_50,
   input  logic               LOCAL_VELOCITY_SEQ_Reset_InHigh,
   input  logic               LOCAL_VELOCITY_SEQ_start_InHigh,
   input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_SEQ_W1_InBus,
   input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_SEQ_W2_InBus,
   input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_SEQ_W3_InBus,
   input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_SEQ_W4_InBus,
   output logic [N_WIDTH-1:0] LOCAL_VELOCITY_SEQ_VX_OutBus,
   output logic [N_WIDTH-1:0] LOCAL_VELOCITY_SEQ_VY_OutBus,
   output logic [N_WIDTH-1:0] LOCAL_VELOCITY_SEQ_WZ_OutBus,
   output logic               LOCAL_VELOCITY_SEQ_busy_OutHigh,
   output logic               LOCAL_VELOCITY_SEQ_done_OutHigh,
   output logic [2:0]         LOCAL_VELOCITY_SEQ_sat_OutBus
);
   localparam int M = N_WIDTH - 1;
   localparam int T = N_WIDTH + 2;
   logic clk, rst, start;
   state_t state_q, state_d;
   logic [N_WIDTH-1:0] w_q [4];
   logic signed [T-1:0] t_q [4];
   logic [M-1:0] smag_q [3];
   logic [2:0] ssgn_q, ssat_q, shsat_q, sat_q;
   logic [N_WIDTH-1:0] sh_q [3];
   logic [N_WIDTH-1:0] vx_q, vy_q, wz_q;
   logic busy_q, done_q;
   logic signed [31:0] s [3];
   logic [1:0] ch;
   logic mul_en, mul_done, mul_sat, psign;
   logic [M-1:0] mul_a, mul_b, mul_mag;
   logic [N_WIDTH-1:0] pres;
   assign clk = LOCAL_VELOCITY_SEQ_CLOCK_50;
   assign rst = LOCAL_VELOCITY_SEQ_Reset_InHigh;
   assign start = LOCAL_VELOCITY_SEQ_start_InHigh;
   always_comb begin
      s[0] = 32'(t_q[0]) + 32'(t_q[1]) + 32'(t_q[2]) + 32'(t_q[3]);
      s[1] = 32'(t_q[1]) + 32'(t_q[2]) - 32'(t_q[0]) - 32'(t_q[3]);
      s[2] = 32'(t_q[1]) + 32'(t_q[3]) - 32'(t_q[0]) - 32'(t_q[2]);
      ch = (state_q == MUL_VY) ? 2'd1 : (state_q == MUL_WZ) ? 2'd2 : 2'd0;
      mul_en = (state_q == MUL_VX) || (state_q == MUL_VY) || (state_q == MUL_WZ);
      mul_a = (ch == 2'd2) ? K_ANG[M-1:0] : K_LIN[M-1:0];
      mul_b = smag_q[ch];
      psign = ((ch == 2'd2) ? K_ANG[M] : K_LIN[M]) ^ ssgn_q[ch];
      pres = psign ? N_WIDTH'(sm_neg(32'({1'b0, mul_mag}), N_WIDTH)) : {1'b0, mul_mag};
      state_d = (state_q == IDLE) ? (start ? CAPTURE : IDLE) :
                (state_q == CAPTURE) ? SUM :
                (state_q == SUM) ? MUL_VX :
                (state_q == DONE) ? IDLE :
                mul_done ? state_t'(state_q + 3'd1) : state_q;
   end
   sm_serial_mult #(.N_WIDTH(N_WIDTH), .Q_WIDTH(Q_WIDTH)) u_mult (
      .clk(clk),
      .rst(rst),
      .en_i(mul_en),
      .a_i(mul_a),
      .b_i(mul_b),
      .mag_o(mul_mag),
      .sat_o(mul_sat),
      .done_o(mul_done)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         w_q <= '{default: '0};
         t_q <= '{default: '0};
         smag_q <= '{default: '0};
         sh_q <= '{default: '0};
         ssgn_q <= '0;
         ssat_q <= '0;
         shsat_q <= '0;
         sat_q <= '0;
         vx_q <= '0;
         vy_q <= '0;
         wz_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q <= state_q == DONE;
         if (state_q == IDLE && start) begin
            w_q <= '{LOCAL_VELOCITY_SEQ_W1_InBus, LOCAL_VELOCITY_SEQ_W2_InBus,
                     LOCAL_VELOCITY_SEQ_W3_InBus, LOCAL_VELOCITY_SEQ_W4_InBus};
            busy_q <= 1'b1;
         end
         if (state_q == CAPTURE)
            for (int i = 0; i < 4; i++) t_q[i] <= T'(sm_to_tc(32'(w_q[i]), N_WIDTH));
         if (state_q == SUM)
            for (int i = 0; i < 3; i++) begin
               {smag_q[i], ssat_q[i]} <= (M + 1)'(tc_to_sm_sat(s[i], N_WIDTH));
               ssgn_q[i] <= s[i][31];
            end
         if (mul_done) begin
            sh_q[ch] <= pres;
            shsat_q[ch] <= ssat_q[ch] | mul_sat;
         end
         if (state_q == DONE) begin
            vx_q <= sh_q[0];
            vy_q <= sh_q[1];
            wz_q <= sh_q[2];
            sat_q <= shsat_q;
            busy_q <= 1'b0;
         end
      end
   assign LOCAL_VELOCITY_SEQ_VX_OutBus = vx_q;
   assign LOCAL_VELOCITY_SEQ_VY_OutBus = vy_q;
   assign LOCAL_VELOCITY_SEQ_WZ_OutBus = wz_q;
   assign LOCAL_VELOCITY_SEQ_busy_OutHigh = busy_q;
   assign LOCAL_VELOCITY_SEQ_done_OutHigh = done_q;
   assign LOCAL_VELOCITY_SEQ_sat_OutBus = sat_q;
endmodule

// File: tb/tb_local_velocity_seq.sv
// tb_local_velocity_seq: directed vectors with hand-computed results for local_velocity_seq.
module tb_local_velocity_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [16:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0;
   logic [16:0] vx, vy, wz;
   logic busy, done;
   logic [2:0] sat;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   local_velocity_seq dut (
      .LOCAL_VELOCITY_SEQ_CLOCK_50(clk),
      .LOCAL_VELOCITY_SEQ_Reset_InHigh(rst),
      .LOCAL_VELOCITY_SEQ_start_InHigh(start),
      .LOCAL_VELOCITY_SEQ_W1_InBus(w1),
      .LOCAL_VELOCITY_SEQ_W2_InBus(w2),
      .LOCAL_VELOCITY_SEQ_W3_InBus(w3),
      .LOCAL_VELOCITY_SEQ_W4_InBus(w4),
      .LOCAL_VELOCITY_SEQ_VX_OutBus(vx),
      .LOCAL_VELOCITY_SEQ_VY_OutBus(vy),
      .LOCAL_VELOCITY_SEQ_WZ_OutBus(wz),
      .LOCAL_VELOCITY_SEQ_busy_OutHigh(busy),
      .LOCAL_VELOCITY_SEQ_done_OutHigh(done),
      .LOCAL_VELOCITY_SEQ_sat_OutBus(sat)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic set_w(input logic [16:0] a, b, c, d);
      w1 = a;
      w2 = b;
      w3 = c;
      w4 = d;
   endtask
   task automatic run(input string tag, input logic [16:0] a, b, c, d,
                      input logic [16:0] evx, evy, ewz, input logic [2:0] esat);
      int lat;
      lat = -1;
      set_w(a, b, c, d);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
      for (int i = 1; i <= 60 && lat < 0; i++) begin
         cyc();
         if (i == 50) chk({tag, " busy_c50"}, 32'(busy), 32'd1);
         if (done) lat = i;
      end
      chk({tag, " latency"}, 32'(lat), 32'd51);
      chk({tag, " vx"}, 32'(vx), 32'(evx));
      chk({tag, " vy"}, 32'(vy), 32'(evy));
      chk({tag, " wz"}, 32'(wz), 32'(ewz));
      chk({tag, " sat"}, 32'(sat), 32'(esat));
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      cyc();
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, " vx_hold"}, 32'(vx), 32'(evx));
   endtask
   initial begin
      int dones, lat;
      repeat (3) cyc();
      chk("reset vx", 32'(vx), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      rst = 1'b0;
      cyc();
      chk("post_reset sat", 32'(sat), 32'd0);
      chk("post_reset wz", 32'(wz), 32'd0);
      run("t1_plus10", 17'h00A00, 17'h00A00, 17'h00A00, 17'h00A00, 17'h00050, 17'h00000, 17'h00000, 3'b000);
      run("t2_w1only", 17'h00400, 17'h00000, 17'h00000, 17'h00000, 17'h00008, 17'h10008, 17'h10014, 3'b000);
      run("t3_no_neg0", 17'h00100, 17'h10100, 17'h00000, 17'h00000, 17'h00000, 17'h10004, 17'h1000A, 3'b000);
      run("t4_vx_sat", 17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h001FF, 17'h00000, 17'h00000, 3'b001);
      run("neg10", 17'h10A00, 17'h10A00, 17'h10A00, 17'h10A00, 17'h10050, 17'h00000, 17'h00000, 3'b000);
      run("neg_vx_sat", 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h101FF, 17'h00000, 17'h00000, 3'b001);
      run("vy_sat", 17'h1FFFF, 17'h0FFFF, 17'h0FFFF, 17'h1FFFF, 17'h00000, 17'h001FF, 17'h00000, 3'b010);
      run("wz_sat", 17'h1FFFF, 17'h0FFFF, 17'h1FFFF, 17'h0FFFF, 17'h00000, 17'h00000, 17'h004FF, 3'b100);
      run("minus_zero_in", 17'h10000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 3'b000);
      run("mixed_trunc", 17'h00300, 17'h10100, 17'h00080, 17'h10040, 17'h00004, 17'h10006, 17'h10017, 3'b000);
      // Test 5: extra starts while busy are dropped; inputs change after capture.
      set_w(17'h00A00, 17'h00A00, 17'h00A00, 17'h00A00);
      start = 1'b1;
      cyc();
      start = 1'b0;
      dones = 0;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         cyc();
         if (i == 3) set_w(17'h00400, 17'h10100, 17'h0FFFF, 17'h00000);
         if (i == 5 || i == 30) start = 1'b1;
         if (i == 6 || i == 31) start = 1'b0;
         if (done) begin
            dones++;
            lat = i;
         end
      end
      chk("t5 done_count", 32'(dones), 32'd1);
      chk("t5 latency", 32'(lat), 32'd51);
      chk("t5 vx", 32'(vx), 32'h00050);
      chk("t5 vy", 32'(vy), 32'h00000);
      chk("t5 sat", 32'(sat), 32'd0);
      // Test 6: asynchronous reset mid-computation aborts everything.
      set_w(17'h00400, 17'h00000, 17'h00000, 17'h00000);
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (20) cyc();
      #2 rst = 1'b1;
      #1;
      chk("t6 async vx", 32'(vx), 32'd0);
      chk("t6 async busy", 32'(busy), 32'd0);
      chk("t6 async done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      dones = 0;
      for (int i = 1; i <= 60; i++) begin
         cyc();
         if (done) dones++;
      end
      chk("t6 no_done", 32'(dones), 32'd0);
      chk("t6 vx_zero", 32'(vx), 32'd0);
      chk("t6 wz_zero", 32'(wz), 32'd0);
      run("t6_restart", 17'h00A00, 17'h00A00, 17'h00A00, 17'h00A00, 17'h00050, 17'h00000, 17'h00000, 3'b000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/local_velocity_seq.md
Name: local_velocity_seq

Overview:
Parametrised successor of the mecanum forward-kinematics block. It computes vx = (w1+w2+w3+w4)·K_LIN, vy = (−w1+w2+w3−w4)·K_LIN and wz = (−w1+w2−w3+w4)·K_ANG in the codebase's sign-magnitude fixed-point format (1 sign bit, N_WIDTH−1 magnitude bits, Q_WIDTH fraction bits). It adds four things:
- a start/busy/done handshake;
- saturating arithmetic with per-channel flags;
- separate linear and angular coefficients;
- one shared serial shift-add multiplier, time-multiplexed over the three channels.

It sits between the wheel-encoder velocity estimators and the odometry integrator.

Parameters:
N_WIDTH, 17, total word width (sign + magnitude).
Q_WIDTH, 8, fraction bits.
K_LIN, 17'h00002, coefficient r/4, sign-magnitude U(N,Q), must be non-negative (0.0078125).
K_ANG, 17'h00005, coefficient r/(4(lx+ly)), sign-magnitude U(N,Q), must be non-negative (0.01953125).

Ports:
LOCAL_VELOCITY_SEQ_CLOCK_50  in  1  system clock, 50 MHz
LOCAL_VELOCITY_SEQ_Reset_InHigh  in  1  reset, asynchronous, active-high
LOCAL_VELOCITY_SEQ_start_InHigh  in  1  request a computation; sampled only in IDLE
LOCAL_VELOCITY_SEQ_W1_InBus .. W4_InBus  in  N_WIDTH each  wheel speeds in rad/s, sign-magnitude
LOCAL_VELOCITY_SEQ_VX_OutBus  out  N_WIDTH  local vx in m/s
LOCAL_VELOCITY_SEQ_VY_OutBus  out  N_WIDTH  local vy in m/s
LOCAL_VELOCITY_SEQ_WZ_OutBus  out  N_WIDTH  local wz in rad/s
LOCAL_VELOCITY_SEQ_busy_OutHigh  out  1  high from the start-accept edge until done
LOCAL_VELOCITY_SEQ_done_OutHigh  out  1  one-cycle pulse when all three outputs have updated
LOCAL_VELOCITY_SEQ_sat_OutBus  out  3  saturation flags {wz,vy,vx}, updated together with the outputs

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE;
  - VX/VY/WZ = 0, sat = 0, busy = 0, done = 0;
  - internal sum, accumulator and counter registers = 0.
- Reset mid-operation aborts the computation: no done pulse, outputs stay 0.
- State machine: IDLE → CAPTURE → SUM → MUL_VX → MUL_VY → MUL_WZ → DONE → IDLE.
- IDLE:
  - if start = 1, latch W1..W4, set busy = 1, go to CAPTURE;
  - otherwise hold outputs.
- CAPTURE (1 cycle): convert latched inputs to internal two's complement, N_WIDTH+2 bits wide.
- SUM (1 cycle):
  - form the three signed sums;
  - clamp each to magnitude ≤ 2^(N_WIDTH−1)−1 and record a per-channel sum-saturation bit;
  - register each sum as sign + magnitude;
  - a zero magnitude always gets sign 0, so −0 never appears.
- MUL_x (N_WIDTH−1 cycles each):
  - serial shift-add, one magnitude bit of the sum per cycle, LSB first, into a 2(N_WIDTH−1)-bit accumulator;
  - the multiplicand is K_LIN for vx/vy and K_ANG for wz;
  - final magnitude = accumulator >> Q_WIDTH (truncate);
  - if it exceeds 2^(N_WIDTH−1)−1, clamp it and set the product-saturation bit;
  - sign = sum sign XOR coefficient sign, forced to 0 when the magnitude is 0;
  - the result goes into a shadow register.
- DONE (1 cycle):
  - VX/VY/WZ and sat load simultaneously from the shadow registers;
  - done = 1, busy = 0 at this edge's output;
  - next state is IDLE.
- sat[i] = sum-saturation OR product-saturation for channel i.
- Latency: done is high in cycle k + 3 + 3·(N_WIDTH−1), where k is the start-sampling edge. This is 51 cycles for N_WIDTH = 17. Outputs are stable from that cycle until the next DONE.
- start while busy is ignored; it is not queued.
- start held high continuously produces back-to-back computations. The next start is sampled in the IDLE cycle following DONE.
- Inputs may change after the start edge without affecting the current result.
- Outputs never glitch between DONE pulses.

Decomposition:
- Package local_velocity_pkg:
  - default N/Q widths;
  - state enumeration;
  - MAX_MAG constant;
  - functions sm_to_tc(), tc_to_sm_sat() (returns magnitude + sat bit) and sm_neg() (sign flip with −0 suppression).
- One sub-module, sm_serial_mult: parametrised N/Q, start/done, magnitude-only serial shift-add with truncation and saturation. It is instantiated once and muxed across the three channels by the FSM.

Test Plan (N=17, Q=8, defaults):
1. W1..W4 = 0x00A00 (+10.0), pulse start → done at cycle 51; VX = 0x00050 (0.3125), VY = 0x00000, WZ = 0x00000, sat = 3'b000.
2. W1 = 0x00400 (+4.0), others 0 → VX = 0x00008, VY = 0x10008, WZ = 0x10014, sat = 0.
3. W1 = 0x00100, W2 = 0x10100, W3 = W4 = 0 → VX = 0x00000 (not 0x10000), VY = 0x10004, WZ = 0x1000A.
4. W1..W4 = 0x0FFFF → vx sum saturates: VX = 0x001FF, sat[0] = 1; VY = 0, WZ = 0, sat[2:1] = 0.
5. Start, then start pulses at cycles 5 and 30 → exactly one done (cycle 51); busy high cycles 1–50; result matches the first-captured inputs even though W changed at cycle 3.
6. Start, assert reset asynchronously at cycle 20 for 2 cycles → outputs/busy/done = 0 immediately, no done pulse; a new start with test 1 stimulus gives test 1 results with the same latency.
